bench_run_sequencer: RTL and testbench
======================================

// Module: bench_run_sequencer
// PURPOSE
//  Sequences one benchmark DUT run (e.g. an Ixxxx_rst core): holds the DUT in reset,
//  releases it for a fixed run window, and compresses its single-bit observation output
//  into a MISR signature plus a ones-count. The result is offered over a valid/ready
//  handshake to the capture/logging side. Sits between the bench controller and one DUT.
// PARAMETERS
//  RST_CYCLES  2       cycles dut_rst_o is held high after start (>=1)
//  RUN_CYCLES  16      cycles obs_i is sampled with the DUT out of reset (>=1)
//  SIG_W       16      signature width (>=2)
//  POLY        16'h1021 MISR feedback polynomial, SIG_W bits
//  SEED        '0      signature value loaded on start and abort
//  CNT_W       $clog2(RUN_CYCLES+1)  width of ones counter (derived)
// PORTS
//  CK           in   1      clock, all logic on posedge
//  reset        in   1      synchronous, active-high
//  start_i      in   1      run request; honoured only in IDLE
//  abort_i      in   1      cancel current run
//  obs_i        in   1      DUT observation bit (output_single)
//  dut_rst_o    out  1      reset to DUT
//  dut_run_o    out  1      high during sampling window
//  busy_o       out  1      state != IDLE
//  res_valid_o  out  1      signature/count valid
//  res_ready_i  in   1      consumer accepts result
//  sig_o        out  SIG_W  MISR signature
//  ones_o       out  CNT_W  count of obs_i==1 samples in window
// BEHAVIOUR
//  - Reset: state IDLE, dut_rst_o=1, dut_run_o=0, busy_o=0, res_valid_o=0, sig_o=SEED, ones_o=0.
//  - States: IDLE -> DUT_RST -> RUN -> DONE -> IDLE. All outputs registered.
//  - IDLE: dut_rst_o=1. start_i=1 -> DUT_RST; sig<=SEED, ones<=0, cnt<=0.
//  - DUT_RST: dut_rst_o=1 for exactly RST_CYCLES cycles, then RUN.
//  - RUN: dut_rst_o=0, dut_run_o=1 for exactly RUN_CYCLES cycles; each cycle
//    sig <= (sig<<1) ^ (sig[SIG_W-1] ? POLY : 0) ^ {'0,obs_i}; ones <= ones + obs_i.
//    Last sample -> DONE.
//  - DONE: dut_rst_o=0, res_valid_o=1; sig_o/ones_o stable while valid && !ready.
//    res_ready_i=1 -> IDLE next edge (res_valid_o=0). ready without valid: ignored.
//  - Latency: start sampled at edge e -> res_valid_o high after edge e+RST_CYCLES+RUN_CYCLES.
//  - start_i outside IDLE ignored (no queuing), incl. start with ready in DONE.
//  - abort_i in DUT_RST/RUN/DONE -> IDLE next edge: dut_rst_o=1, res_valid_o=0,
//    sig<=SEED, ones<=0. abort wins over ready and over phase completion. In IDLE: no effect;
//    abort && start in IDLE -> stay IDLE.
//  - reset mid-run: all state to reset values next edge, overrides abort/start.
//  - Counters: internal phase counter width $clog2(max(RST_CYCLES,RUN_CYCLES)+1); no wrap
//    possible; ones_o saturation not needed (max RUN_CYCLES fits CNT_W).
// STRUCTURE
//  - bench_seq_pkg: typedef enum logic [1:0] {IDLE,DUT_RST,RUN,DONE} seq_state_t;
//    function misr_step(sig, bit, poly) shared with other bench compressors.
//  - Sub-module bench_misr (SIG_W, POLY, SEED): clear, en, bit_i -> sig_o; FSM + counters
//    remain in bench_run_sequencer.
// TESTING  (RST_CYCLES=2, RUN_CYCLES=4, SIG_W=8, POLY=8'h1D, SEED=0 unless stated)
//  1 reset then start pulse, obs_i=0 -> dut_rst_o high 2 cycles, dut_run_o 4 cycles,
//    res_valid_o after edge e+6; sig_o=8'h00, ones_o=0.
//  2 obs_i=1 throughout RUN -> sig_o=8'h0F, ones_o=4; hold ready=0 5 cycles -> values stable.
//  3 RUN_CYCLES=9, obs_i=1 first RUN cycle only -> sig_o=8'h1D (feedback path), ones_o=1.
//  4 abort_i in 2nd RUN cycle -> IDLE next edge, dut_rst_o=1, res_valid_o never rises,
//    sig_o=8'h00; following start yields normal result.
//  5 start_i pulsed during RUN and with res_ready_i in DONE -> ignored, one result only,
//    busy_o=0 after handshake.
//  6 reset asserted in DUT_RST -> reset values next edge; abort+start in IDLE -> stays IDLE.

Source files
------------

// File: rtl/bench_seq_pkg.sv
// rtl/bench_seq_pkg.sv - shared types and MISR step function for bench sequencers
//   seq_state_t : run sequencer phases IDLE -> DUT_RST -> RUN -> DONE
//   misr_step   : one MISR update on a value of up to MISR_MAX_W bits
package bench_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DUT_RST = 2'd1,
        RUN     = 2'd2,
        DONE    = 2'd3
    } seq_state_t;

    localparam int MISR_MAX_W = 32;

    // Works on a 32-bit container so compressors of any width up to 32 can share it;
    // the result is masked back to 'width' bits.
    function automatic logic [MISR_MAX_W-1:0] misr_step(
        input logic [MISR_MAX_W-1:0] sig,
        input logic                  obs_bit,
        input logic [MISR_MAX_W-1:0] poly,
        input int                    width
    );
        logic [MISR_MAX_W-1:0] msb_sh;
        logic [MISR_MAX_W-1:0] mask;
        logic [MISR_MAX_W-1:0] nxt;
        msb_sh = sig >> (width - 1);
        mask   = (width >= MISR_MAX_W) ? '1 : ((32'd1 << width) - 32'd1);
        nxt    = (sig << 1) ^ (msb_sh[0] ? poly : '0) ^ {31'd0, obs_bit};
        return nxt & mask;
    endfunction

endpackage

// File: rtl/bench_misr.sv
// rtl/bench_misr.sv - single-input MISR signature register
//   clk, reset : clock, synchronous active-high reset (loads SEED)
//   clear      : synchronous load of SEED
//   en         : shift in bit_i this cycle
//   sig_o      : current signature
module bench_misr
    import bench_seq_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021,
    parameter logic [SIG_W-1:0] SEED  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic             bit_i,
    output logic [SIG_W-1:0] sig_o
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sig_o <= SEED;
        end else if (en) begin
            sig_o <= SIG_W'(misr_step(32'(sig_o), bit_i, 32'(POLY), SIG_W));
        end
    end

endmodule

// File: rtl/bench_run_sequencer.sv
// rtl/bench_run_sequencer.sv - reset/run window sequencer with MISR result handshake
//   CK, reset            : clock, synchronous active-high reset
//   start_i, abort_i     : run request (IDLE only) / cancel current run
//   obs_i                : DUT observation bit, sampled during the run window
//   dut_rst_o, dut_run_o : DUT reset, sampling window indicator
//   busy_o               : sequencer not idle
//   res_valid_o/ready_i  : result handshake
//   sig_o, ones_o        : MISR signature, count of ones sampled
module bench_run_sequencer
    import bench_seq_pkg::*;
#(
    parameter int               RST_CYCLES = 2,
    parameter int               RUN_CYCLES = 16,
    parameter int               SIG_W      = 16,
    parameter logic [SIG_W-1:0] POLY       = 16'h1021,
    parameter logic [SIG_W-1:0] SEED       = '0,
    parameter int               CNT_W      = $clog2(RUN_CYCLES + 1)
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             obs_i,
    output logic             dut_rst_o,
    output logic             dut_run_o,
    output logic             busy_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [SIG_W-1:0] sig_o,
    output logic [CNT_W-1:0] ones_o
);

    localparam int PH_MAX = (RST_CYCLES > RUN_CYCLES) ? RST_CYCLES : RUN_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    seq_state_t      state;
    logic [PH_W-1:0] cnt;
    logic            misr_clear;
    logic            misr_en;

    // Abort is ignored in IDLE, and abort+start in IDLE keeps the old result.
    always_comb begin
        misr_clear = 1'b0;
        misr_en    = 1'b0;
        if (state == IDLE) begin
            misr_clear = start_i && !abort_i;
        end else begin
            misr_clear = abort_i;
            misr_en    = (state == RUN) && !abort_i;
        end
    end

    bench_misr #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk   (CK),
        .reset (reset),
        .clear (misr_clear),
        .en    (misr_en),
        .bit_i (obs_i),
        .sig_o (sig_o)
    );

    always_ff @(posedge CK) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            ones_o      <= '0;
            dut_rst_o   <= 1'b1;
            dut_run_o   <= 1'b0;
            busy_o      <= 1'b0;
            res_valid_o <= 1'b0;
        end else if (state != IDLE && abort_i) begin
            // Abort beats phase completion and the result handshake.
            state       <= IDLE;
            cnt         <= '0;
            ones_o      <= '0;
            dut_rst_o   <= 1'b1;
            dut_run_o   <= 1'b0;
            busy_o      <= 1'b0;
            res_valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i && !abort_i) begin
                        state  <= DUT_RST;
                        cnt    <= '0;
                        ones_o <= '0;
                        busy_o <= 1'b1;
                    end
                end
                DUT_RST: begin
                    if (cnt == PH_W'(RST_CYCLES - 1)) begin
                        state     <= RUN;
                        cnt       <= '0;
                        dut_rst_o <= 1'b0;
                        dut_run_o <= 1'b1;
                    end else begin
                        cnt <= cnt + PH_W'(1);
                    end
                end
                RUN: begin
                    ones_o <= ones_o + CNT_W'(obs_i);
                    if (cnt == PH_W'(RUN_CYCLES - 1)) begin
                        state       <= DONE;
                        cnt         <= '0;
                        dut_run_o   <= 1'b0;
                        res_valid_o <= 1'b1;
                    end else begin
                        cnt <= cnt + PH_W'(1);
                    end
                end
                DONE: begin
                    if (res_ready_i) begin
                        state       <= IDLE;
                        res_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        dut_rst_o   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bench_run_sequencer.sv
// tb/tb_bench_run_sequencer.sv - self-checking bench for bench_run_sequencer
module tb_bench_run_sequencer;

    localparam int RST = 2;

    logic       CK = 1'b0;
    logic       reset;
    logic       start [2];
    logic       abort [2];
    logic       obs   [2];
    logic       ready [2];
    logic       dut_rst_v [2];
    logic       dut_run_v [2];
    logic       busy_v    [2];
    logic       valid_v   [2];
    logic [7:0] sig_v     [2];
    logic [2:0] ones_a;
    logic [3:0] ones_b;
    logic [3:0] ones_v    [2];

    int tests = 0;
    int fails = 0;

    assign ones_v[0] = {1'b0, ones_a};
    assign ones_v[1] = ones_b;

    always #5 CK = ~CK;

    bench_run_sequencer #(
        .RST_CYCLES(RST), .RUN_CYCLES(4), .SIG_W(8), .POLY(8'h1D), .SEED(8'h00)
    ) u_a (
        .CK(CK), .reset(reset), .start_i(start[0]), .abort_i(abort[0]), .obs_i(obs[0]),
        .dut_rst_o(dut_rst_v[0]), .dut_run_o(dut_run_v[0]), .busy_o(busy_v[0]),
        .res_valid_o(valid_v[0]), .res_ready_i(ready[0]), .sig_o(sig_v[0]), .ones_o(ones_a)
    );

    bench_run_sequencer #(
        .RST_CYCLES(RST), .RUN_CYCLES(9), .SIG_W(8), .POLY(8'h1D), .SEED(8'h00)
    ) u_b (
        .CK(CK), .reset(reset), .start_i(start[1]), .abort_i(abort[1]), .obs_i(obs[1]),
        .dut_rst_o(dut_rst_v[1]), .dut_run_o(dut_run_v[1]), .busy_o(busy_v[1]),
        .res_valid_o(valid_v[1]), .res_ready_i(ready[1]), .sig_o(sig_v[1]), .ones_o(ones_b)
    );

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Signature as a GF(2) polynomial remainder: bit i of the window contributes
    // x^(n-1-i) mod (x^8 + 0x1D).
    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
    endfunction

    function automatic logic [7:0] ref_sig(input logic [15:0] pat, input int n);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h00;
        for (int i = 0; i < n; i++) begin
            if (pat[i]) begin
                p = 8'h01;
                for (int j = 0; j < n - 1 - i; j++) p = xtime(p);
                r = r ^ p;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_ones(input logic [15:0] pat, input int n);
        logic [15:0] m;
        m = (16'd1 << n) - 16'd1;
        return 32'($countones(pat & m));
    endfunction

    task automatic check_idle(input int sel, input string tag);
        check({tag, "_rst"},   32'(dut_rst_v[sel]), 32'd1);
        check({tag, "_run"},   32'(dut_run_v[sel]), 32'd0);
        check({tag, "_busy"},  32'(busy_v[sel]),    32'd0);
        check({tag, "_valid"}, 32'(valid_v[sel]),   32'd0);
    endtask

    // One run: start, drive pat through the window, optionally abort at cycle
    // abort_at (counted from the start edge), hold ready low rw cycles, handshake.
    task automatic do_run(input int sel, input logic [15:0] pat, input int rw,
                          input bit inj, input int abort_at);
        int n;
        logic [7:0]  es;
        logic [31:0] eo;
        n  = (sel == 0) ? 4 : 9;
        es = ref_sig(pat, n);
        eo = ref_ones(pat, n);
        start[sel] = 1'b1;
        step();
        start[sel] = 1'b0;
        for (int k = 0; k < RST + n; k++) begin
            check("ph_rst",   32'(dut_rst_v[sel]), 32'(k < RST));
            check("ph_run",   32'(dut_run_v[sel]), 32'(k >= RST));
            check("ph_valid", 32'(valid_v[sel]),   32'd0);
            check("ph_busy",  32'(busy_v[sel]),    32'd1);
            obs[sel] = (k >= RST) ? pat[k - RST] : 1'b0;
            if (inj && k == RST + 1) start[sel] = 1'b1;
            if (k == abort_at) begin
                abort[sel] = 1'b1;
                step();
                abort[sel] = 1'b0;
                obs[sel]   = 1'b0;
                check_idle(sel, "abort");
                check("abort_sig",  32'(sig_v[sel]),  32'h00);
                check("abort_ones", 32'(ones_v[sel]), 32'd0);
                for (int w = 0; w < 3; w++) begin
                    step();
                    check("abort_novalid", 32'(valid_v[sel]), 32'd0);
                end
                return;
            end
            step();
            start[sel] = 1'b0;
        end
        obs[sel] = 1'b0;
        check("done_valid", 32'(valid_v[sel]),   32'd1);
        check("done_rst",   32'(dut_rst_v[sel]), 32'd0);
        check("done_run",   32'(dut_run_v[sel]), 32'd0);
        check("done_sig",   32'(sig_v[sel]),     32'(es));
        check("done_ones",  32'(ones_v[sel]),    eo);
        for (int w = 0; w < rw; w++) begin
            step();
            check("hold_valid", 32'(valid_v[sel]), 32'd1);
            check("hold_sig",   32'(sig_v[sel]),   32'(es));
            check("hold_ones",  32'(ones_v[sel]),  eo);
        end
        if (inj) start[sel] = 1'b1;
        ready[sel] = 1'b1;
        step();
        ready[sel] = 1'b0;
        start[sel] = 1'b0;
        check_idle(sel, "hs");
        check("hs_sig_kept", 32'(sig_v[sel]), 32'(es));
        step();
        check("post_busy",  32'(busy_v[sel]),  32'd0);
        check("post_valid", 32'(valid_v[sel]), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            start[s] = 1'b0; abort[s] = 1'b0; obs[s] = 1'b0; ready[s] = 1'b0;
        end
        step();
        step();
        for (int s = 0; s < 2; s++) begin
            check_idle(s, "reset");
            check("reset_sig",  32'(sig_v[s]),  32'h00);
            check("reset_ones", 32'(ones_v[s]), 32'd0);
        end
        reset = 1'b0;
        step();

        // ready with no valid pending does nothing
        ready[0] = 1'b1;
        step();
        ready[0] = 1'b0;
        check_idle(0, "stray_ready");

        do_run(0, 16'h0000, 0, 1'b0, -1);
        do_run(0, 16'h000F, 5, 1'b0, -1);
        check("fixed_0F", 32'(ref_sig(16'h000F, 4)), 32'h0F);
        do_run(1, 16'h0001, 2, 1'b0, -1);
        check("fixed_1D", 32'(sig_v[1]), 32'h1D);

        do_run(0, 16'h000F, 0, 1'b0, RST + 1);
        do_run(0, 16'h0005, 1, 1'b0, -1);
        do_run(0, 16'h000F, 0, 1'b0, RST + 3);
        do_run(1, 16'h01FF, 0, 1'b0, RST + 8);
        do_run(0, 16'h000A, 1, 1'b1, -1);

        // reset during DUT_RST
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle(0, "midreset");
        check("midreset_sig",  32'(sig_v[0]),  32'h00);
        check("midreset_ones", 32'(ones_v[0]), 32'd0);

        // abort + start in IDLE keeps the sequencer idle
        abort[0] = 1'b1;
        start[0] = 1'b1;
        step();
        abort[0] = 1'b0;
        start[0] = 1'b0;
        check_idle(0, "abort_start");
        step();
        check_idle(0, "abort_start2");

        for (int r = 0; r < 24; r++) begin
            do_run(int'($urandom_range(0, 1)), 16'($urandom), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
